if_stage: RTL and testbench

//  Instruction-fetch stage of the 5-stage MIPS pipeline; producer of fs_to_ds_bus and consumer of br_bus.

---
 rtl/if_stage_pkg.sv | 17 +
 rtl/if_stage.sv | 102 ++++++++++
 tb/tb_if_stage.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared widths, fetch-stage state encodings and the default boot address
// for the instruction-fetch stage.
package if_stage_pkg;

  localparam int FS_TO_DS_BUS_WD = 64;
  localparam int BR_BUS_WD       = 33;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;

  typedef enum logic [1:0] {
    FS_EMPTY = 2'd0,
    FS_REQ   = 2'd1,
    FS_WAIT  = 2'd2,
    FS_FULL  = 2'd3
  } fs_state_e;

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding SRAM-like request, one-entry inst
// buffer, delay-slot aware redirect with a latched branch target.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_req,
  output logic                       inst_sram_wr,
  output logic [1:0]                 inst_sram_size,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  input  logic                       inst_sram_addr_ok,
  input  logic                       inst_sram_data_ok,
  input  logic [31:0]                inst_sram_rdata
);

  fs_state_e   state, state_next;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        br_buf_valid;
  logic [31:0] br_buf;

  logic        br_taken;
  logic [31:0] br_target;
  logic        handoff;
  logic [31:0] nextpc;

  assign br_taken  = br_bus[32];
  assign br_target = br_bus[31:0];

  // A branch still in ID wins; otherwise a target latched while the slot was in flight.
  assign nextpc = br_taken     ? br_target :
                  br_buf_valid ? br_buf    :
                                 pc + 32'd4;

  always_comb begin
    state_next     = state;
    handoff        = 1'b0;
    inst_sram_req  = 1'b0;
    fs_to_ds_valid = 1'b0;
    case (state)
      FS_EMPTY: state_next = FS_REQ;
      FS_REQ: begin
        inst_sram_req = 1'b1;
        if (inst_sram_addr_ok) state_next = FS_WAIT;
      end
      FS_WAIT: begin
        if (inst_sram_data_ok) state_next = FS_FULL;
      end
      FS_FULL: begin
        fs_to_ds_valid = 1'b1;
        if (ds_allowin) begin
          handoff    = 1'b1;
          state_next = FS_REQ;
        end
      end
      default: state_next = FS_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= FS_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc           <= RESET_PC;
      inst         <= 32'd0;
      br_buf_valid <= 1'b0;
      br_buf       <= 32'd0;
    end else begin
      if (state == FS_WAIT && inst_sram_data_ok) begin
        inst <= inst_sram_rdata;
      end
      if (handoff) begin
        pc           <= nextpc;
        br_buf_valid <= 1'b0;
      end else if (br_taken) begin
        br_buf       <= br_target;
        br_buf_valid <= 1'b1;
      end
    end
  end

  assign fs_to_ds_bus    = {inst, pc};
  assign inst_sram_addr  = pc;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'd2;
  assign inst_sram_wdata = 32'd0;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: cycle-accurate SRAM handshake driven from tasks,
// instruction words derived from the fetch address.
module tb_if_stage;

  logic        clk;
  logic        resetn;
  logic        ds_allowin;
  logic [32:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  int checks;
  int passed;

  if_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ds_allowin        (ds_allowin),
    .br_bus            (br_bus),
    .fs_to_ds_valid    (fs_to_ds_valid),
    .fs_to_ds_bus      (fs_to_ds_bus),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], 16'hc0de};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered just after the edge that put the stage into REQ for exp_pc; returns
  // just after the handoff edge, so the stage is in REQ for the following fetch.
  task automatic fetch(input logic [31:0] exp_pc, input int addr_wait, input int data_wait,
                       input int hold, input logic [32:0] br_req, input logic [32:0] br_wait,
                       input logic [32:0] br_full);
    br_bus = br_req;
    for (int i = 0; i < addr_wait; i++) begin
      chk("req_hold", {63'd0, inst_sram_req}, 64'd1);
      chk("addr_hold", {32'd0, inst_sram_addr}, {32'd0, exp_pc});
      inst_sram_addr_ok = 1'b0;
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = 32'hdeadbeef;
      step();
    end
    chk("req", {63'd0, inst_sram_req}, 64'd1);
    chk("addr", {32'd0, inst_sram_addr}, {32'd0, exp_pc});
    chk("req_size_wr", {61'd0, inst_sram_size, inst_sram_wr}, {61'd0, 2'd2, 1'b0});
    inst_sram_addr_ok = 1'b1;
    inst_sram_data_ok = 1'b0;
    step();
    br_bus = br_wait;
    for (int i = 0; i < data_wait; i++) begin
      chk("wait_req_valid", {62'd0, inst_sram_req, fs_to_ds_valid}, 64'd0);
      chk("wait_pc", {32'd0, fs_to_ds_bus[31:0]}, {32'd0, exp_pc});
      inst_sram_addr_ok = 1'b1;
      inst_sram_data_ok = 1'b0;
      step();
    end
    chk("wait_req_valid", {62'd0, inst_sram_req, fs_to_ds_valid}, 64'd0);
    chk("wait_pc", {32'd0, fs_to_ds_bus[31:0]}, {32'd0, exp_pc});
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = inst_of(exp_pc);
    step();
    br_bus = br_full;
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid_req", {62'd0, fs_to_ds_valid, inst_sram_req}, {62'd0, 2'b10});
      chk("hold_bus", fs_to_ds_bus, {inst_of(exp_pc), exp_pc});
      ds_allowin        = 1'b0;
      inst_sram_addr_ok = 1'b1;
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = 32'h0badf00d;
      step();
    end
    chk("full_valid_req", {62'd0, fs_to_ds_valid, inst_sram_req}, {62'd0, 2'b10});
    chk("full_bus", fs_to_ds_bus, {inst_of(exp_pc), exp_pc});
    ds_allowin        = 1'b1;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    step();
    br_bus = 33'd0;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    resetn            = 1'b0;
    ds_allowin        = 1'b1;
    br_bus            = 33'd0;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = 32'd0;

    step();
    step();
    chk("rst_valid_req", {62'd0, fs_to_ds_valid, inst_sram_req}, 64'd0);
    chk("rst_bus", fs_to_ds_bus, {32'd0, 32'hbfc00000});
    resetn = 1'b1;
    #1;
    chk("rel_no_change", {62'd0, fs_to_ds_valid, inst_sram_req}, 64'd0);
    step();

    // Back-to-back fetches, zero extra latency
    fetch(32'hbfc00000, 0, 0, 0, 33'd0, 33'd0, 33'd0);
    fetch(32'hbfc00004, 0, 0, 0, 33'd0, 33'd0, 33'd0);
    fetch(32'hbfc00008, 0, 0, 0, 33'd0, 33'd0, 33'd0);
    // ID stalls for 5 cycles with the instruction held in FULL
    fetch(32'hbfc0000c, 0, 0, 5, 33'd0, 33'd0, 33'd0);
    // Slow addr_ok and data_ok; this is the branch instruction
    fetch(32'hbfc00010, 3, 2, 0, 33'd0, 33'd0, 33'd0);
    // Delay slot fetched while the branch sits in ID the whole time
    fetch(32'hbfc00014, 0, 0, 0, {1'b1, 32'hbfc00100}, {1'b1, 32'hbfc00100},
          {1'b1, 32'hbfc00100});
    fetch(32'hbfc00100, 0, 0, 0, 33'd0, 33'd0, 33'd0);
    // Branch leaves ID while the slot waits for data; target must be buffered
    fetch(32'hbfc00104, 0, 0, 1, 33'd0, {1'b1, 32'hbfc00200}, 33'd0);
    fetch(32'hbfc00200, 0, 0, 0, 33'd0, 33'd0, 33'd0);
    fetch(32'hbfc00204, 0, 0, 0, 33'd0, 33'd0, 33'd0);

    // Reset in the middle of an outstanding fetch
    chk("pre_rst_addr", {32'd0, inst_sram_addr}, {32'd0, 32'hbfc00208});
    inst_sram_addr_ok = 1'b1;
    step();
    chk("pre_rst_wait", {62'd0, fs_to_ds_valid, inst_sram_req}, 64'd0);
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h5ca1ab1e;
    resetn            = 1'b0;
    #1;
    chk("async_rst_outs", {62'd0, fs_to_ds_valid, inst_sram_req}, 64'd0);
    chk("async_rst_bus", fs_to_ds_bus, {32'd0, 32'hbfc00000});
    step();
    resetn = 1'b1;
    step();
    chk("post_rst_req", {63'd0, inst_sram_req}, 64'd1);
    chk("post_rst_addr", {32'd0, inst_sram_addr}, {32'd0, 32'hbfc00000});
    step();
    chk("stale_data_ok", {62'd0, fs_to_ds_valid, inst_sram_req}, {62'd0, 2'b01});
    chk("stale_bus", fs_to_ds_bus, {32'd0, 32'hbfc00000});
    inst_sram_data_ok = 1'b0;
    fetch(32'hbfc00000, 0, 0, 0, 33'd0, 33'd0, 33'd0);
    fetch(32'hbfc00004, 0, 0, 0, 33'd0, 33'd0, 33'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
